data_mem_ctrl: RTL and testbench

//  Data-memory controller directly downstream of the single-cycle RV32I core's memory stage.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/data_mem_ctrl_dmem_array.sv | 29 ++
 rtl/data_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic WE_STORE = 1'b1;
  localparam logic WE_LOAD  = 1'b0;

  // Number of word-index bits needed to address a RAM of the given depth.
  function automatic int index_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       byte_we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write and read-before-write registered read on an enabled access.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_we[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the RV32I memory stage: captures a request,
// waits a fixed number of cycles, commits/reads the RAM and pulses valid.
import dmem_pkg::*;

module data_mem_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDRESS     = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  request,
  input  logic                  we_re,
  input  logic [3:0]            mask,
  input  logic [ADDRESS-1:0]    address,
  input  logic [DATA_WIDTH-1:0] store_data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  valid,
  output logic                  error,
  output logic                  busy
);

  localparam int IDX_W = index_width(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t state;
  logic [3:0]  wait_cnt;

  logic                  hold_we;
  logic [3:0]            hold_mask;
  logic [ADDRESS-1:0]    hold_addr;
  logic [DATA_WIDTH-1:0] hold_data;

  logic                  cur_we;
  logic [3:0]            cur_mask;
  logic [ADDRESS-1:0]    cur_addr;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  cur_in_range;
  logic [IDX_W-1:0]      cur_idx;

  logic        enter_resp;
  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic        load_ok;
  logic        unused_addr_lsb;

  // With zero wait states the RAM is accessed in the same cycle the request is
  // seen, so the live inputs are used in IDLE and the captured copies otherwise.
  always_comb begin
    cur_we   = hold_we;
    cur_mask = hold_mask;
    cur_addr = hold_addr;
    cur_data = hold_data;
    if (state == IDLE) begin
      cur_we   = we_re;
      cur_mask = mask;
      cur_addr = address;
      cur_data = store_data;
    end
  end

  // Decode the word index and range, and decide whether this edge enters RESP.
  always_comb begin
    cur_in_range    = (cur_addr[ADDRESS-1:IDX_W+2] == '0);
    cur_idx         = cur_addr[IDX_W+1:2];
    unused_addr_lsb = ^cur_addr[1:0];
    enter_resp      = 1'b0;
    if (state == IDLE && request && WAIT_STATES == 0) begin
      enter_resp = 1'b1;
    end else if (state == WAIT && wait_cnt == 4'd0) begin
      enter_resp = 1'b1;
    end
    ram_en = enter_resp && cur_in_range;
    ram_be = (cur_we == WE_STORE) ? cur_mask : 4'b0000;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .en      (ram_en),
    .byte_we (ram_be),
    .idx     (cur_idx),
    .wdata   (cur_data[31:0]),
    .rdata   (ram_rdata)
  );

  // Transaction FSM: capture, wait-state countdown and registered response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      valid     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      load_ok   <= 1'b0;
      hold_we   <= WE_LOAD;
      hold_mask <= 4'b0000;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (request) begin
            hold_we   <= we_re;
            hold_mask <= mask;
            hold_addr <= address;
            hold_data <= store_data;
            busy      <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (enter_resp) begin
        valid   <= 1'b1;
        error   <= ~cur_in_range;
        load_ok <= cur_in_range && (cur_we == WE_LOAD);
      end
    end
  end

  // Loads that were out of range, and stores, present a zero word.
  assign load_data = load_ok ? DATA_WIDTH'(ram_rdata) : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: three instances (0, 1 and 3 wait
// states) sharing data inputs, each with its own request line.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        req     [3];
  logic        valid_w [3];
  logic        error_w [3];
  logic        busy_w  [3];
  logic [31:0] load_w  [3];

  int errors = 0;
  int checks = 0;
  int wlist [3] = '{0, 1, 3};

  logic [31:0] model [int];

  always #5 clk = ~clk;

  data_mem_ctrl #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .request(req[0]), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data), .load_data(load_w[0]),
    .valid(valid_w[0]), .error(error_w[0]), .busy(busy_w[0]));

  data_mem_ctrl #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .rst(rst), .request(req[1]), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data), .load_data(load_w[1]),
    .valid(valid_w[1]), .error(error_w[1]), .busy(busy_w[1]));

  data_mem_ctrl #(.WAIT_STATES(3)) dut2 (
    .clk(clk), .rst(rst), .request(req[2]), .we_re(we_re), .mask(mask),
    .address(address), .store_data(store_data), .load_data(load_w[2]),
    .valid(valid_w[2]), .error(error_w[2]), .busy(busy_w[2]));

  // Byte-lane merge of a store into an existing word.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Drive one transaction on an instance; return latency (-1 on timeout) and response.
  task automatic apply_stimulus(input int inst, input logic we, input logic [3:0] m,
                                input logic [31:0] a, input logic [31:0] d,
                                output int lat, output logic err, output logic [31:0] ld);
    bit got;
    got = 0; lat = -1; err = 1'b0; ld = '0;
    @(negedge clk);
    we_re = we; mask = m; address = a; store_data = d; req[inst] = 1'b1;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk); #1;
      if (valid_w[inst]) begin
        got = 1; lat = n; err = error_w[inst]; ld = load_w[inst];
        req[inst] = 1'b0;
      end
    end
    req[inst] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid_w[i] !== 1'b0 || error_w[i] !== 1'b0 || busy_w[i] !== 1'b0 || load_w[i] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_state[%0d]: got v=%b e=%b b=%b ld=%h expected all zero",
                 i, valid_w[i], error_w[i], busy_w[i], load_w[i]);
      end
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic err; logic [31:0] ld; int seen;
    apply_stimulus(1, 1'b1, 4'hF, 32'h40, 32'h11223344, lat, err, ld);
    @(negedge clk);
    we_re = 1'b1; mask = 4'hF; address = 32'h40; store_data = 32'hFFFFFFFF; req[1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_w[1] !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_wait_busy: got %b expected 1", busy_w[1]);
    end
    rst = 1'b1; seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (valid_w[1]) seen++;
    end
    req[1] = 1'b0; rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      if (valid_w[1]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("[TB] FAIL reset_abort_valid: got %0d pulses expected 0", seen);
    end
    apply_stimulus(1, 1'b0, 4'h0, 32'h40, 32'h0, lat, err, ld);
    checks++;
    if (ld !== 32'h11223344 || lat != 2) begin
      errors++; $display("[TB] FAIL reset_abort_data: got %h lat %0d expected 11223344 lat 2", ld, lat);
    end
  endtask

  task automatic test_store_load();
    int lat; logic err; logic [31:0] ld;
    apply_stimulus(1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, err, ld);
    checks++;
    if (lat != 2 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL store_latency: got lat %0d err %b expected lat 2 err 0", lat, err);
    end
    apply_stimulus(1, 1'b0, 4'h0, 32'h10, 32'h0, lat, err, ld);
    checks++;
    if (lat != 2 || err !== 1'b0 || ld !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL word_load: got %h lat %0d err %b expected DEADBEEF lat 2 err 0", ld, lat, err);
    end
  endtask

  task automatic test_masking();
    int lat; logic err; logic [31:0] ld;
    apply_stimulus(1, 1'b1, 4'b0010, 32'h11, 32'h0000AB00, lat, err, ld);
    apply_stimulus(1, 1'b0, 4'h0, 32'h10, 32'h0, lat, err, ld);
    checks++;
    if (ld !== 32'hDEADABEF) begin
      errors++; $display("[TB] FAIL byte_mask: got %h expected DEADABEF", ld);
    end
    apply_stimulus(1, 1'b1, 4'b1100, 32'h10, 32'h12340000, lat, err, ld);
    apply_stimulus(1, 1'b0, 4'h0, 32'h12, 32'h0, lat, err, ld);
    checks++;
    if (ld !== 32'h1234ABEF) begin
      errors++; $display("[TB] FAIL half_mask: got %h expected 1234ABEF", ld);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic err; logic [31:0] ld;
    apply_stimulus(1, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, lat, err, ld);
    apply_stimulus(1, 1'b1, 4'hF, 32'h0000_1000, 32'h55555555, lat, err, ld);
    checks++;
    if (lat != 2 || err !== 1'b1) begin
      errors++; $display("[TB] FAIL oor_store: got lat %0d err %b expected lat 2 err 1", lat, err);
    end
    apply_stimulus(1, 1'b0, 4'h0, 32'h0, 32'h0, lat, err, ld);
    checks++;
    if (ld !== 32'hCAFEF00D || err !== 1'b0) begin
      errors++; $display("[TB] FAIL oor_no_alias: got %h err %b expected CAFEF00D err 0", ld, err);
    end
    apply_stimulus(1, 1'b0, 4'h0, 32'h0000_1000, 32'h0, lat, err, ld);
    checks++;
    if (ld !== 32'h0 || err !== 1'b1) begin
      errors++; $display("[TB] FAIL oor_load: got %h err %b expected 00000000 err 1", ld, err);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      int nvalid, first, last, gap_bad, busy_low;
      nvalid = 0; first = -1; last = 0; gap_bad = 0; busy_low = 0;
      @(negedge clk);
      we_re = 1'b0; mask = 4'h0; address = 32'h20; req[i] = 1'b1;
      for (int n = 1; n <= 60 && nvalid < 3; n++) begin
        @(posedge clk); #1;
        if (valid_w[i]) begin
          if (nvalid == 0) first = n;
          else if (n - last != wlist[i] + 2) gap_bad++;
          last = n; nvalid++;
          if (nvalid == 3) req[i] = 1'b0;
        end else if (nvalid > 0 && !busy_w[i]) begin
          busy_low++;
        end
      end
      req[i] = 1'b0;
      checks++;
      if (nvalid != 3 || first != wlist[i] + 1 || gap_bad != 0) begin
        errors++;
        $display("[TB] FAIL b2b_timing W=%0d: got %0d pulses first %0d bad gaps %0d expected 3 first %0d bad gaps 0",
                 wlist[i], nvalid, first, gap_bad, wlist[i] + 1);
      end
      checks++;
      if (busy_low != 2) begin
        errors++; $display("[TB] FAIL b2b_bubble W=%0d: got %0d idle cycles expected 2", wlist[i], busy_low);
      end
      @(posedge clk); #1;
      checks++;
      if (busy_w[i] !== 1'b0 || valid_w[i] !== 1'b0) begin
        errors++; $display("[TB] FAIL b2b_idle W=%0d: got busy %b valid %b expected 0 0", wlist[i], busy_w[i], valid_w[i]);
      end
    end
  endtask

  task automatic test_glitch_zero_mask();
    int lat; logic err; logic [31:0] ld; int seen; logic seen_err;
    apply_stimulus(2, 1'b1, 4'hF, 32'h80, 32'hA5A5A5A5, lat, err, ld);
    checks++;
    if (lat != 4) begin
      errors++; $display("[TB] FAIL w3_latency: got %0d expected 4", lat);
    end
    @(negedge clk);
    we_re = 1'b1; mask = 4'hF; address = 32'h80; store_data = 32'h0BADC0DE; req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0; we_re = 1'b0; mask = 4'h0; address = 32'h84; store_data = 32'h0;
    seen = 0; seen_err = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (valid_w[2]) begin seen++; seen_err = error_w[2]; end
    end
    checks++;
    if (seen != 1 || seen_err !== 1'b0) begin
      errors++; $display("[TB] FAIL glitch_valid: got %0d pulses err %b expected 1 pulse err 0", seen, seen_err);
    end
    apply_stimulus(2, 1'b0, 4'h0, 32'h80, 32'h0, lat, err, ld);
    checks++;
    if (ld !== 32'h0BADC0DE) begin
      errors++; $display("[TB] FAIL glitch_data: got %h expected 0BADC0DE", ld);
    end
    apply_stimulus(2, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF, lat, err, ld);
    checks++;
    if (lat != 4 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL zero_mask_resp: got lat %0d err %b expected lat 4 err 0", lat, err);
    end
    apply_stimulus(2, 1'b0, 4'h0, 32'h80, 32'h0, lat, err, ld);
    checks++;
    if (ld !== 32'h0BADC0DE) begin
      errors++; $display("[TB] FAIL zero_mask_data: got %h expected 0BADC0DE", ld);
    end
  endtask

  task automatic test_random();
    int lat; logic err; logic [31:0] ld;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] d;
      d = $urandom;
      apply_stimulus(1, 1'b1, 4'hF, 32'h400 + 32'(k) * 4, d, lat, err, ld);
      model[k] = d;
    end
    for (int t = 0; t < 40; t++) begin
      int k; bit oor; logic we; logic [3:0] m; logic [31:0] a, d;
      k   = $urandom_range(0, 7);
      oor = ($urandom_range(0, 9) == 0);
      a   = oor ? ($urandom | 32'h0000_1000) : ((32'h400 + 32'(k) * 4) | 32'($urandom_range(0, 3)));
      we  = 1'($urandom_range(0, 1));
      m   = 4'($urandom);
      d   = $urandom;
      apply_stimulus(1, we, m, a, d, lat, err, ld);
      checks++;
      if (lat != 2 || err !== logic'(oor)) begin
        errors++; $display("[TB] FAIL rand_resp[%0d]: got lat %0d err %b expected lat 2 err %b", t, lat, err, oor);
      end
      if (!we) begin
        logic [31:0] exp_ld;
        exp_ld = oor ? 32'h0 : model[k];
        checks++;
        if (ld !== exp_ld) begin
          errors++; $display("[TB] FAIL rand_load[%0d] addr %h: got %h expected %h", t, a, ld, exp_ld);
        end
      end else if (!oor) begin
        model[k] = merge(model[k], d, m);
      end
    end
  endtask

  // Bounded run: a hang reports and stops.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; we_re = 1'b0; mask = 4'h0; address = '0; store_data = '0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    test_reset();
    test_reset_mid_wait();
    test_store_load();
    test_masking();
    test_out_of_range();
    test_back_to_back();
    test_glitch_zero_mask();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
